// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers for the display-side blocks.
package vga_timing_pkg;

  localparam int CNT_W   = 12;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 24;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;

  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;

  function automatic int span_total(input int sync, input int back, input int active, input int front);
    return sync + back + active + front;
  endfunction

  function automatic int act_first(input int sync, input int back);
    return sync + back;
  endfunction

  function automatic int act_last(input int sync, input int back, input int active);
    return sync + back + active - 1;
  endfunction

  localparam int H_TOTAL_DEF     = span_total(H_SYNC_DEF, H_BACK_DEF, H_ACTIVE_DEF, H_FRONT_DEF);
  localparam int V_TOTAL_DEF     = span_total(V_SYNC_DEF, V_BACK_DEF, V_ACTIVE_DEF, V_FRONT_DEF);
  localparam int H_ACT_FIRST_DEF = act_first(H_SYNC_DEF, H_BACK_DEF);
  localparam int H_ACT_LAST_DEF  = act_last(H_SYNC_DEF, H_BACK_DEF, H_ACTIVE_DEF);
  localparam int V_ACT_FIRST_DEF = act_first(V_SYNC_DEF, V_BACK_DEF);
  localparam int V_ACT_LAST_DEF  = act_last(V_SYNC_DEF, V_BACK_DEF, V_ACTIVE_DEF);

  // Pin-side control bundle; syncs are active-low so idle means high.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame: 1'b0};

endpackage

// File: rtl/vga_sig_delay.sv
// Fixed-depth shift register with async active-high clear to a chosen value.
module vga_sig_delay #(
  parameter int            W       = 1,
  parameter int            DEPTH   = 1,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= CLR_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: counters drive pixel requests; syncs/de are delayed to meet
// the returning pixel data so everything lands on the pins together.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int PIX_LAT  = 1
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pos_data,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               pix_req,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [PIX_W-1:0]   rgb,
  output logic               frame_start
);

  localparam int   H_TOTAL  = span_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int   V_TOTAL  = span_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_A_LO   = cnt_t'(act_first(H_SYNC, H_BACK));
  localparam cnt_t H_A_HI   = cnt_t'(act_last(H_SYNC, H_BACK, H_ACTIVE));
  localparam cnt_t V_A_LO   = cnt_t'(act_first(V_SYNC, V_BACK));
  localparam cnt_t V_A_HI   = cnt_t'(act_last(V_SYNC, V_BACK, V_ACTIVE));
  localparam cnt_t H_S_END  = cnt_t'(H_SYNC);
  localparam cnt_t V_S_END  = cnt_t'(V_SYNC);

  cnt_t cnt_h;
  cnt_t cnt_v;
  logic h_act;
  logic v_act;
  ctl_t raw;
  ctl_t dly;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + cnt_t'(1);
    end else begin
      cnt_h <= cnt_h + cnt_t'(1);
    end
  end

  assign h_act   = (cnt_h >= H_A_LO) && (cnt_h <= H_A_HI);
  assign v_act   = (cnt_v >= V_A_LO) && (cnt_v <= V_A_HI);
  assign pix_req = h_act && v_act;
  assign pos_x   = pix_req ? coord_t'(cnt_h - H_A_LO) : '0;
  assign pos_y   = pix_req ? coord_t'(cnt_v - V_A_LO) : '0;

  always_comb begin
    raw       = CTL_IDLE;
    raw.hsync = (cnt_h >= H_S_END);
    raw.vsync = (cnt_v >= V_S_END);
    raw.de    = pix_req;
    raw.frame = (cnt_h == '0) && (cnt_v == '0);
  end

  // Matches the pixel source latency so de lines up with the returned pos_data.
  vga_sig_delay #(
    .W      ($bits(ctl_t)),
    .DEPTH  (PIX_LAT),
    .CLR_VAL(CTL_IDLE)
  ) u_ctl_dly (
    .clk(vga_clk),
    .clr(rst),
    .d  (raw),
    .q  (dly)
  );

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
    end else begin
      hsync       <= dly.hsync;
      vsync       <= dly.vsync;
      de          <= dly.de;
      frame_start <= dly.frame;
      rgb         <= dly.de ? pos_data : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default geometry for line-level timing, a shrunken 25x13 raster
// (12x6 visible) at PIX_LAT 1 and 3 so whole frames stay short.
module tb_vga_timing_ctrl;

  logic vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  logic rst;
  logic white = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [23:0] pd_a, rgb_a, pd_s1, rgb_s1, pd_s3, rgb_s3, p3a, p3b;
  logic [9:0]  x_a, y_a, x_s1, y_s1, x_s3, y_s3;
  logic        req_a, hs_a, vs_a, de_a, fs_a;
  logic        req_s1, hs_s1, vs_s1, de_s1, fs_s1;
  logic        req_s3, hs_s3, vs_s3, de_s3, fs_s3;

  // Registered pixel sources returning {0, x, y}.
  always @(posedge vga_clk) pd_a  <= {4'h0, x_a, y_a};
  always @(posedge vga_clk) pd_s1 <= white ? 24'hFFFFFF : {4'h0, x_s1, y_s1};
  always @(posedge vga_clk) begin
    p3a   <= {4'h0, x_s3, y_s3};
    p3b   <= p3a;
    pd_s3 <= p3b;
  end

  vga_timing_ctrl u_dut (
    .vga_clk(vga_clk), .rst(rst), .pos_data(pd_a), .pos_x(x_a), .pos_y(y_a),
    .pix_req(req_a), .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  vga_timing_ctrl #(
    .H_SYNC(6), .H_BACK(4), .H_ACTIVE(12), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(2), .PIX_LAT(1)
  ) u_sm1 (
    .vga_clk(vga_clk), .rst(rst), .pos_data(pd_s1), .pos_x(x_s1), .pos_y(y_s1),
    .pix_req(req_s1), .hsync(hs_s1), .vsync(vs_s1), .de(de_s1), .rgb(rgb_s1), .frame_start(fs_s1)
  );

  vga_timing_ctrl #(
    .H_SYNC(6), .H_BACK(4), .H_ACTIVE(12), .H_FRONT(3),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(6), .V_FRONT(2), .PIX_LAT(3)
  ) u_sm3 (
    .vga_clk(vga_clk), .rst(rst), .pos_data(pd_s3), .pos_x(x_s3), .pos_y(y_s3),
    .pix_req(req_s3), .hsync(hs_s3), .vsync(vs_s3), .de(de_s3), .rgb(rgb_s3), .frame_start(fs_s3)
  );

  task automatic step;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge vga_clk);
    rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({hs_a, vs_a, de_a, fs_a, req_a} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_async_ctl: got %b expected 11000", {hs_a, vs_a, de_a, fs_a, req_a});
    end
    n_checks++;
    if ({rgb_a, x_a, y_a} !== 44'h0) begin
      n_fail++; $display("FAIL reset_async_data: got %h expected 0", {rgb_a, x_a, y_a});
    end
    repeat (3) step();
    n_checks++;
    if ({hs_s3, vs_s3, de_s3, fs_s3, rgb_s3} !== {4'b1100, 24'h0}) begin
      n_fail++; $display("FAIL reset_held_lat3: got %h expected %h", {hs_s3, vs_s3, de_s3, fs_s3, rgb_s3}, {4'b1100, 24'h0});
    end
  endtask

  task automatic test_hsync_default;
    int n, lo, per;
    do_reset();
    n = 0;
    while (hs_a === 1'b1 && n < 10) begin step(); n++; end
    n_checks++;
    if (n != 2) begin n_fail++; $display("FAIL hsync_first_fall: got %0d expected 2", n); end
    n_checks++;
    if ({fs_a, vs_a} !== 2'b10) begin
      n_fail++; $display("FAIL frame_start_at_fall: got fs/vs %b expected 10", {fs_a, vs_a});
    end
    lo = 0;
    while (hs_a === 1'b0 && lo < 200) begin lo++; step(); end
    n_checks++;
    if (lo != 96) begin n_fail++; $display("FAIL hsync_low_width: got %0d expected 96", lo); end
    per = lo;
    while (hs_a === 1'b1 && per < 2000) begin per++; step(); end
    n_checks++;
    if (per != 800) begin n_fail++; $display("FAIL hsync_period: got %0d expected 800", per); end
    n_checks++;
    if (fs_a !== 1'b0) begin n_fail++; $display("FAIL frame_start_line1: got %b expected 0", fs_a); end
  endtask

  task automatic test_pixels_default;
    int k, vlo, run;
    logic [23:0] first, second, last;
    do_reset();
    k = 0; vlo = 0;
    while (de_a !== 1'b1 && k < 30000) begin
      step(); k++;
      if (vs_a === 1'b0) vlo++;
    end
    n_checks++;
    if (k != 28146) begin n_fail++; $display("FAIL first_de_default: got %0d expected 28146", k); end
    n_checks++;
    if (vlo != 1600) begin n_fail++; $display("FAIL vsync_low_default: got %0d expected 1600", vlo); end
    first = rgb_a; second = 'x; last = 'x; run = 0;
    while (de_a === 1'b1 && run < 1000) begin
      last = rgb_a;
      if (run == 1) second = rgb_a;
      run++; step();
    end
    n_checks++;
    if (first !== 24'h000000) begin n_fail++; $display("FAIL rgb_x0y0: got %h expected 000000", first); end
    n_checks++;
    if (second !== {4'h0, 10'd1, 10'd0}) begin
      n_fail++; $display("FAIL rgb_x1y0: got %h expected %h", second, {4'h0, 10'd1, 10'd0});
    end
    n_checks++;
    if (run != 640) begin n_fail++; $display("FAIL de_run_line0: got %0d expected 640", run); end
    n_checks++;
    if (last !== {4'h0, 10'd639, 10'd0}) begin
      n_fail++; $display("FAIL rgb_last_line0: got %h expected %h", last, {4'h0, 10'd639, 10'd0});
    end
  endtask

  task automatic test_frame_small;
    int k, fs_cnt, fs_pos, vlo, vfall, bad, de_cnt;
    logic hs_prev, vs_prev;
    white = 1'b0;
    do_reset();
    k = 0;
    while (fs_s1 !== 1'b1 && k < 10) begin step(); k++; end
    n_checks++;
    if (k != 2) begin n_fail++; $display("FAIL frame_start_first: got %0d expected 2", k); end
    fs_cnt = 0; fs_pos = 0; vlo = 0; vfall = 0; bad = 0; de_cnt = 0;
    hs_prev = hs_s1; vs_prev = vs_s1;
    for (int i = 1; i <= 325; i++) begin
      step();
      if (fs_s1 === 1'b1) begin fs_cnt++; fs_pos = i; end
      if (vs_s1 === 1'b0) vlo++;
      if (de_s1 === 1'b1) de_cnt++;
      if (vs_prev === 1'b1 && vs_s1 === 1'b0) vfall++;
      if ((fs_s1 === 1'b1) !== (vs_prev === 1'b1 && vs_s1 === 1'b0 && hs_prev === 1'b1 && hs_s1 === 1'b0)) bad++;
      hs_prev = hs_s1; vs_prev = vs_s1;
    end
    n_checks++;
    if (fs_cnt != 1 || fs_pos != 325) begin
      n_fail++; $display("FAIL frame_start_period: got count %0d at %0d expected 1 at 325", fs_cnt, fs_pos);
    end
    n_checks++;
    if (vlo != 50) begin n_fail++; $display("FAIL vsync_low_small: got %0d expected 50", vlo); end
    n_checks++;
    if (vfall != 1 || bad != 0) begin
      n_fail++; $display("FAIL sync_coincidence: got falls %0d misaligned %0d expected 1 and 0", vfall, bad);
    end
    n_checks++;
    if (de_cnt != 72) begin n_fail++; $display("FAIL de_per_frame: got %0d expected 72", de_cnt); end
  endtask

  task automatic test_pixels_small;
    logic [27:0] h1 [0:340];
    int hf1, hf3, fd1, fd3, n1, n3, bad1, bad3, align;
    logic [23:0] ex, l0_1, lf_1, lf_3;
    white = 1'b0;
    do_reset();
    hf1 = -1; hf3 = -1; fd1 = -1; fd3 = -1; n1 = 0; n3 = 0; bad1 = 0; bad3 = 0; align = 0;
    l0_1 = 'x; lf_1 = 'x; lf_3 = 'x;
    for (int i = 1; i <= 340; i++) begin
      step();
      h1[i] = {hs_s1, vs_s1, de_s1, fs_s1, rgb_s1};
      if (hf1 < 0 && hs_s1 === 1'b0) hf1 = i;
      if (hf3 < 0 && hs_s3 === 1'b0) hf3 = i;
      if (de_s1 === 1'b1) begin
        if (fd1 < 0) fd1 = i;
        ex = {4'h0, 10'(n1 % 12), 10'(n1 / 12)};
        if (rgb_s1 !== ex) bad1++;
        n1++; lf_1 = rgb_s1;
        if (n1 == 12) l0_1 = rgb_s1;
      end else if (rgb_s1 !== 24'h0) bad1++;
      if (de_s3 === 1'b1) begin
        if (fd3 < 0) fd3 = i;
        ex = {4'h0, 10'(n3 % 12), 10'(n3 / 12)};
        if (rgb_s3 !== ex) bad3++;
        n3++; lf_3 = rgb_s3;
      end else if (rgb_s3 !== 24'h0) bad3++;
      if (i >= 3 && {hs_s3, vs_s3, de_s3, fs_s3, rgb_s3} !== h1[i-2]) align++;
    end
    n_checks++;
    if (hf1 != 2 || hf3 != 4) begin
      n_fail++; $display("FAIL hsync_fall_lat: got %0d/%0d expected 2/4", hf1, hf3);
    end
    n_checks++;
    if (fd1 != 137 || fd3 != 139) begin
      n_fail++; $display("FAIL first_de_lat: got %0d/%0d expected 137/139", fd1, fd3);
    end
    n_checks++;
    if (n1 != 72 || bad1 != 0) begin
      n_fail++; $display("FAIL pixels_lat1: got count %0d bad %0d expected 72 and 0", n1, bad1);
    end
    n_checks++;
    if (n3 != 72 || bad3 != 0) begin
      n_fail++; $display("FAIL pixels_lat3: got count %0d bad %0d expected 72 and 0", n3, bad3);
    end
    n_checks++;
    if (l0_1 !== {4'h0, 10'd11, 10'd0}) begin
      n_fail++; $display("FAIL rgb_last_line0_small: got %h expected %h", l0_1, {4'h0, 10'd11, 10'd0});
    end
    n_checks++;
    if (lf_1 !== {4'h0, 10'd11, 10'd5} || lf_3 !== {4'h0, 10'd11, 10'd5}) begin
      n_fail++; $display("FAIL rgb_last_frame: got %h/%h expected %h", lf_1, lf_3, {4'h0, 10'd11, 10'd5});
    end
    n_checks++;
    if (align != 0) begin n_fail++; $display("FAIL lat3_shift2: got %0d misaligned clocks expected 0", align); end
  endtask

  task automatic test_white_small;
    int k, de_cnt, bad;
    white = 1'b1;
    do_reset();
    k = 0;
    while (fs_s1 !== 1'b1 && k < 10) begin step(); k++; end
    de_cnt = 0; bad = 0;
    for (int i = 0; i < 325; i++) begin
      if (de_s1 === 1'b1) begin
        de_cnt++;
        if (rgb_s1 !== 24'hFFFFFF) bad++;
      end else if (rgb_s1 !== 24'h0) bad++;
      step();
    end
    white = 1'b0;
    n_checks++;
    if (de_cnt != 72) begin n_fail++; $display("FAIL white_de_count: got %0d expected 72", de_cnt); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL white_rgb: got %0d wrong clocks expected 0", bad); end
  endtask

  task automatic test_mid_reset;
    int n, lo, per;
    white = 1'b0;
    do_reset();
    repeat (190) step();
    n_checks++;
    if ({de_s1, req_s1, rgb_s1, x_s1, y_s1} !== {2'b11, 4'h0, 10'd3, 10'd2, 10'd5, 10'd2}) begin
      n_fail++; $display("FAIL pre_reset_pixel: got de %b rgb %h x %0d y %0d expected de 1 rgb %h x 5 y 2",
                         de_s1, rgb_s1, x_s1, y_s1, {4'h0, 10'd3, 10'd2});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({hs_s1, vs_s1, de_s1, fs_s1, req_s1} !== 5'b11000 || {rgb_s1, x_s1, y_s1} !== 44'h0) begin
      n_fail++; $display("FAIL mid_reset_async: got ctl %b data %h expected 11000 and 0",
                         {hs_s1, vs_s1, de_s1, fs_s1, req_s1}, {rgb_s1, x_s1, y_s1});
    end
    repeat (2) @(negedge vga_clk);
    rst = 1'b0;
    n = 0;
    while (hs_s1 === 1'b1 && n < 10) begin step(); n++; end
    lo = 0;
    while (hs_s1 === 1'b0 && lo < 50) begin lo++; step(); end
    per = lo;
    while (hs_s1 === 1'b1 && per < 100) begin per++; step(); end
    n_checks++;
    if (n != 2 || lo != 6 || per != 25) begin
      n_fail++; $display("FAIL restart_timing: got fall %0d low %0d period %0d expected 2 6 25", n, lo, per);
    end
  endtask

  initial begin
    rst = 1'b0;
    #5 rst = 1'b1;
    test_reset();
    test_hsync_default();
    test_pixels_default();
    test_frame_small();
    test_pixels_small();
    test_white_small();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_SYNC 96 hsync pulse width in clocks; H_BACK 48 h back porch; H_ACTIVE 640 visible pixels per line; H_FRONT 16 h front porch; V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_FRONT 10 the vertical equivalents in lines; PIX_LAT 1 pixel-source latency in clocks, legal range 1-4.
REQ-002 SHALL have ports (name, direction, width, meaning):
- vga_clk in 1: pixel clock, 25 MHz; the block uses one clock only.
- rst in 1: asynchronous, active-high reset.
- pos_data in 24: RGB888 pixel returned by the pixel source, PIX_LAT clocks after the request.
- pos_x out 10: requested column, 0-639.
- pos_y out 10: requested row, 0-479.
- pix_req out 1: pos_x/pos_y address a visible pixel.
- hsync out 1: horizontal sync, active-low.
- vsync out 1: vertical sync, active-low.
- de out 1: data enable at the pins.
- rgb out 24: pixel to the DAC/pins.
- frame_start out 1: one-clock pulse at the pins marking the start of a frame.

Function
REQ-003 SHALL keep cnt_h 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (800 at defaults), incrementing every clock and wrapping to 0.
REQ-004 SHALL keep cnt_v 0..V_TOTAL-1 (525 at defaults), incrementing only when cnt_h = H_TOTAL-1 and wrapping to 0 when cnt_v = V_TOTAL-1 on that same clock.
REQ-005 SHALL order each line and each frame as sync, back porch, active, front porch; the h active window is cnt_h 144..783 and the v active window is cnt_v 35..514 at defaults.
REQ-006 SHALL drive pix_req combinationally from the counters, high exactly when both counters are inside their active windows.
REQ-007 SHALL drive pos_x = cnt_h-(H_SYNC+H_BACK) and pos_y = cnt_v-(V_SYNC+V_BACK) while pix_req = 1, and 0/0 otherwise.
REQ-008 SHALL derive raw sync/active/frame flags from the counters: hsync_raw = 0 while cnt_h < H_SYNC; vsync_raw = 0 while cnt_v < V_SYNC; frame_raw = 1 when cnt_h = 0 and cnt_v = 0.
REQ-009 SHALL delay hsync_raw, vsync_raw, pix_req and frame_raw through a PIX_LAT-deep pipeline, then one output register, so hsync, vsync, de and frame_start reach the pins PIX_LAT+1 clocks after the counter state that produced them.
REQ-010 SHALL register rgb <= (delayed pix_req) ? pos_data : 24'h000000, so rgb is aligned with de and is forced black whenever de = 0.
REQ-011 SHALL produce exactly H_ACTIVE*V_ACTIVE de-high clocks (307200 at defaults) per frame period of H_TOTAL*V_TOTAL clocks (420000 at defaults).
REQ-012 SHALL assert frame_start on the same clock as the falling edges of both hsync and vsync.
REQ-013 SHALL not take pos_data into account when pix_req is low; its value there is don't-care.

Reset
REQ-014 SHALL, while rst = 1, immediately and asynchronously force cnt_h = 0, cnt_v = 0, all pipeline stages cleared (syncs inactive), hsync = 1, vsync = 1, de = 0, rgb = 0, frame_start = 0, pos_x = 0, pos_y = 0, pix_req = 0.
REQ-015 SHALL hold cnt_h = 0 and cnt_v = 0 during the first clock after rst falls, so timing restarts from frame start; reset asserted mid-frame abandons that frame with no partial pulses.

Structure
REQ-016 SHALL take the default timing constants, H_TOTAL/V_TOTAL and the active-window bounds from a shared package vga_timing_pkg, reused by the display-side blocks.
REQ-017 SHALL implement the PIX_LAT alignment with one sub-module, vga_sig_delay: a parameterised width/depth shift register with async active-high clear.

Verification
REQ-018 Release reset, PIX_LAT = 1 -> first hsync falling edge 2 clocks after release; hsync low 96 clocks; hsync period 800 clocks.
REQ-019 Free-run one frame -> vsync low for 1600 clocks; vsync period 420000 clocks; exactly one frame_start per frame, coincident with the vsync falling edge.
REQ-020 Bench pixel model registers pos_data <= {4'h0, pos_x, pos_y} -> first de-high rgb = 24'h000000 (x0, y0); last de-high rgb of line 0 = {4'h0, 10'd639, 10'd0}; last pixel of the frame = {4'h0, 10'd639, 10'd479}.
REQ-021 Hold pos_data = 24'hFFFFFF for a full frame -> rgb = 0 on every de-low clock; 307200 de-high clocks, all with rgb = FFFFFF.
REQ-022 Assert rst at cnt_h = 400 of line 100 -> in the same clock hsync = 1, vsync = 1, de = 0, rgb = 0; after release, timing is identical to REQ-018.
REQ-023 Repeat REQ-020 with PIX_LAT = 3 and the model's pos_data delayed 3 clocks -> same rgb values at the same de positions; sync edges shifted +2 clocks versus PIX_LAT = 1.
